// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : encoder_pkg
// Purpose  : Shared types, constants and the priority-encode helper for the
//            front-panel keypad encoder.
// Contents : BCD_W, NUM_KEYS, DEFAULT_DEBOUNCE_CYCLES, KEY_WORD_W,
//            state_t {IDLE, PRESSED}, key_word_t {none, code}, KEY_NONE,
//            prio_encode()
// Revision : 1.0 - initial release
// ============================================================================
package encoder_pkg;

  localparam int BCD_W                   = 4;
  localparam int NUM_KEYS                = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 20;
  localparam int KEY_WORD_W              = BCD_W + 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  // Encoded key word: 'none' set means no key is present; 'code' is then 0.
  typedef struct packed {
    logic             none;
    logic [BCD_W-1:0] code;
  } key_word_t;

  localparam key_word_t KEY_NONE = key_word_t'({1'b1, {BCD_W{1'b0}}});

  // Lowest set index wins. Scanning from the top down lets the lowest
  // index overwrite any higher one found earlier.
  function automatic key_word_t prio_encode(input logic [NUM_KEYS-1:0] keys);
    key_word_t w;
    w = KEY_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) begin
        w.none = 1'b0;
        w.code = BCD_W'(i);
      end
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : key_debouncer
// Purpose  : Stable-count filter on the encoded {none, code} key word. The
//            output follows the input only after the input has been sampled
//            unchanged on CYCLES consecutive edges; any change restarts the
//            count.
// Ports    : clk      - system clock, rising edge
//            resetn   - synchronous active-low reset
//            i_clear  - synchronous clear: output forced to "none", count 0
//            i_word   - encoded key word from the priority encoder
//            o_word   - filtered key word (registered)
// Revision : 1.0 - initial release
// ============================================================================
module key_debouncer
  import encoder_pkg::*;
#(
  parameter int CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_clear,
  input  logic [KEY_WORD_W-1:0] i_word,
  output logic [KEY_WORD_W-1:0] o_word
);

  localparam int             CNT_W   = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES);

  logic [KEY_WORD_W-1:0] r_prev;
  logic [KEY_WORD_W-1:0] r_out;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;

  // r_cnt is the number of consecutive samples equal to r_prev. A new value
  // counts as its own first sample; the count saturates at CNT_MAX.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_word != r_prev) begin
      w_cnt_next = CNT_W'(1);
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_prev <= KEY_NONE;
      r_cnt  <= '0;
      r_out  <= KEY_NONE;
    end else if (i_clear) begin
      r_prev <= KEY_NONE;
      r_cnt  <= '0;
      r_out  <= KEY_NONE;
    end else begin
      r_prev <= i_word;
      r_cnt  <= w_cnt_next;
      // Reaching the threshold on this sample accepts the current input.
      if (w_cnt_next == CNT_MAX) begin
        r_out <= i_word;
      end
    end
  end

  assign o_word = r_out;

endmodule
`default_nettype wire

// File: rtl/encoder.sv
`default_nettype none
// ============================================================================
// Module   : encoder
// Purpose  : Keypad encoder for the microwave front panel. Synchronizes the
//            ten one-hot digit keys, priority encodes them to BCD, optionally
//            debounces, and issues a single active-low load strobe per press.
// Config   : ENCODER_DEBOUNCE_EN - when defined, a key_debouncer stage of
//            DEBOUNCE_CYCLES sits between the priority encoder and the state
//            logic; otherwise every synchronized change is used directly.
// Ports    : clk      - 1 kHz system clock, rising edge
//            resetn   - synchronous active-low reset
//            key      - key[i]=1 means digit i pressed (asynchronous)
//            enablen  - active-low enable; 1 treats all keys as released
//            d        - BCD code of the last accepted digit (0-9)
//            loadn    - active-low one-cycle strobe on an accepted press
//            pressed  - high while an accepted key is held
// Revision : 1.0 - initial release
// ============================================================================
module encoder
  import encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                enablen,
  output logic [BCD_W-1:0]    d,
  output logic                loadn,
  output logic                pressed
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("encoder: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_keys_gated;
  key_word_t           w_enc;
  key_word_t           w_filt;

  state_t              r_state;
  state_t              w_state_next;
  logic [BCD_W-1:0]    r_d;
  logic [BCD_W-1:0]    w_d_next;
  logic                r_loadn;
  logic                w_loadn_next;
  logic                r_pressed;
  logic                w_pressed_next;

  // Two-flop synchronizer for the asynchronous key lines.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_keys_gated = enablen ? '0 : r_sync2;
  assign w_enc        = prio_encode(w_keys_gated);

`ifdef ENCODER_DEBOUNCE_EN
  logic [KEY_WORD_W-1:0] w_filt_word;

  // Disabling also clears any count in progress, so a key still held when
  // enablen falls must pass a full stable window before it is accepted.
  key_debouncer #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk     (clk),
    .resetn  (resetn),
    .i_clear (enablen),
    .i_word  (w_enc),
    .o_word  (w_filt_word)
  );

  assign w_filt = key_word_t'(w_filt_word);
`else
  assign w_filt = w_enc;
`endif

  // Acceptance state register and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_d       <= '0;
      r_loadn   <= 1'b1;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_d       <= w_d_next;
      r_loadn   <= w_loadn_next;
      r_pressed <= w_pressed_next;
    end
  end

  // Only the IDLE -> PRESSED transition loads d and strobes. A change from
  // one key to another (including release and new press in one sample)
  // never passes through "none", so it stays in PRESSED with d held.
  always_comb begin
    w_state_next   = r_state;
    w_d_next       = r_d;
    w_loadn_next   = 1'b1;
    w_pressed_next = r_pressed;
    case (r_state)
      IDLE: begin
        if (!w_filt.none) begin
          w_state_next   = PRESSED;
          w_d_next       = w_filt.code;
          w_loadn_next   = 1'b0;
          w_pressed_next = 1'b1;
        end
      end
      PRESSED: begin
        if (w_filt.none) begin
          w_state_next   = IDLE;
          w_pressed_next = 1'b0;
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_pressed_next = 1'b0;
      end
    endcase
  end

  assign d       = r_d;
  assign loadn   = r_loadn;
  assign pressed = r_pressed;

endmodule
`default_nettype wire

// File: tb/tb_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder
// Purpose  : Self-checking bench for the keypad encoder. Expected strobes
//            (digit and edge number) are queued as keys are driven and
//            checked when loadn falls; level checks cover d and pressed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder;

  localparam int N = 20;
`ifdef ENCODER_DEBOUNCE_EN
  localparam int LAT    = N + 3;  // key change to strobe, in edges
  localparam int EN_LAT = N + 1;  // enablen fall to strobe, key already synced
`else
  localparam int LAT    = 3;
  localparam int EN_LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [9:0] key;
  logic       enablen;
  logic [3:0] d;
  logic       loadn;
  logic       pressed;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] d;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  encoder #(
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .key     (key),
    .enablen (enablen),
    .d       (d),
    .loadn   (loadn),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every loadn low must match the oldest queued press.
  always @(negedge clk) begin
    if (resetn === 1'b1 && loadn !== 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL strobe_unexpected: loadn=%b d=%0d at edge %0d, required no strobe", loadn, d, cyc);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checks++;
        assert (d === mon_e.d) else begin
          errors++;
          $error("FAIL strobe_d: observed %0d expected %0d", d, mon_e.d);
        end
        checks++;
        assert (cyc === mon_e.cyc) else begin
          errors++;
          $error("FAIL strobe_edge: observed %0d expected %0d", cyc, mon_e.cyc);
        end
        checks++;
        assert (pressed === 1'b1) else begin
          errors++;
          $error("FAIL strobe_pressed: observed %b expected 1", pressed);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_strobe(input logic [3:0] dv, input int at);
    exp_t e;
    e.d   = dv;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d strobes outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    enablen = 1'b0;
    key     = '0;
    step(3);
    chk_d  ("reset_d",       d,       4'd0);
    chk_bit("reset_loadn",   loadn,   1'b1);
    chk_bit("reset_pressed", pressed, 1'b0);
    resetn = 1'b1;

    // Long idle with no keys.
    for (int i = 0; i < 3000; i++) begin
      step(1);
      chk_d  ("idle_d",       d,       4'd0);
      chk_bit("idle_pressed", pressed, 1'b0);
    end

    // Key 5 held for 50 cycles, then released.
    key = 10'b0000100000;
    expect_strobe(4'd5, cyc + LAT);
    step(50);
    chk_d  ("k5_d",       d,       4'd5);
    chk_bit("k5_pressed", pressed, 1'b1);
    key = '0;
    step(LAT - 1);
    chk_bit("k5_pressed_before_release", pressed, 1'b1);
    step(1);
    chk_bit("k5_released", pressed, 1'b0);
    chk_d  ("k5_d_held",   d,       4'd5);
    drain(LAT + 10);

    // Keys 1 and 9 together: lowest index wins.
    key = 10'b1000000010;
    expect_strobe(4'd1, cyc + LAT);
    step(40);
    chk_d("k1_9_d", d, 4'd1);
    key = '0;
    step(LAT + 5);
    chk_bit("k1_9_released", pressed, 1'b0);
    drain(LAT + 10);

    // Key 2, then switch to key 6 without release: no second strobe.
    key = 10'b0000000100;
    expect_strobe(4'd2, cyc + LAT);
    step(40);
    key = 10'b0001000000;
    step(LAT + 10);
    chk_d  ("change_d",       d,       4'd2);
    chk_bit("change_pressed", pressed, 1'b1);
    key = '0;
    step(LAT + 5);
    chk_bit("change_released", pressed, 1'b0);
    chk_d  ("change_d_held",   d,       4'd2);
    drain(LAT + 10);

    // Key 3 held while disabled, then enabled.
    enablen = 1'b1;
    key     = 10'b0000001000;
    step(100);
    chk_bit("dis_pressed", pressed, 1'b0);
    chk_d  ("dis_d",       d,       4'd2);
    enablen = 1'b0;
    expect_strobe(4'd3, cyc + EN_LAT);
    step(EN_LAT + 5);
    chk_d  ("en_d",       d,       4'd3);
    chk_bit("en_pressed", pressed, 1'b1);
    key = '0;
    step(LAT + 5);
    drain(LAT + 10);

`ifdef ENCODER_DEBOUNCE_EN
    // Key 7 chattering in 10-cycle bursts, then held.
    for (int i = 0; i < 5; i++) begin
      key = 10'b0010000000;
      step(10);
      key = '0;
      step(10);
    end
    chk_d  ("bounce_d",       d,       4'd3);
    chk_bit("bounce_pressed", pressed, 1'b0);
    key = 10'b0010000000;
    expect_strobe(4'd7, cyc + LAT);
    step(LAT + 5);
    chk_d("bounce_held_d", d, 4'd7);
    key = '0;
    step(LAT + 5);
    drain(LAT + 10);
`endif

    // Key 4 held across a 2-cycle reset.
    key = 10'b0000010000;
    expect_strobe(4'd4, cyc + LAT);
    step(LAT + 5);
    chk_d("rst_pre_d", d, 4'd4);
    resetn = 1'b0;
    step(1);
    chk_d  ("rst1_d",       d,       4'd0);
    chk_bit("rst1_loadn",   loadn,   1'b1);
    chk_bit("rst1_pressed", pressed, 1'b0);
    step(1);
    chk_d  ("rst2_d",     d,     4'd0);
    chk_bit("rst2_loadn", loadn, 1'b1);
    resetn = 1'b1;
    expect_strobe(4'd4, cyc + LAT);
    step(LAT + 5);
    chk_d  ("rst_post_d",       d,       4'd4);
    chk_bit("rst_post_pressed", pressed, 1'b1);
    key = '0;
    step(LAT + 5);
    chk_bit("rst_post_released", pressed, 1'b0);
    drain(LAT + 10);

    step(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
